// File: rtl/spi_slave_if.sv
// Parallel and serial signal bundle for the SPI responder.
// The slave modport is the responder's view; the master modport is the
// view of whatever drives the serial pins and the transmit word.
interface spi_slave_if;
    logic [31:0] data_transmit;
    logic        mlb;
    logic [31:0] data_received;
    logic        done;
    logic        busy;
    logic        frame_error;
    logic        sclk;
    logic        ss;
    logic        din;
    logic        dout;
    logic        dout_en;

    modport slave (
        input  data_transmit, mlb, sclk, ss, din,
        output data_received, done, busy, frame_error, dout, dout_en
    );

    modport master (
        output data_transmit, mlb, sclk, ss, din,
        input  data_received, done, busy, frame_error, dout, dout_en
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/ss/din on the system clock and shifts a
// 32-bit frame in and out (MSB- or LSB-first). Mode: sclk idles low, data
// sampled on sclk rise and changed on sclk fall, ss active-low, MISO idles 1.
module spi_slave #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    spi_slave_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_SS  = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam logic [5:0] FRAME_CNT  = 6'(FRAME_BITS);
    // The synchronizers reset to the "deselected" pattern, so the real pin
    // level is only visible once the chain and history flop have refilled.
    localparam logic [3:0] SETTLE_CNT = 4'(SYNC_STAGES + 1);

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sclk_hist_q;
    logic                   ss_hist_q;

    logic sclk_s;
    logic ss_s;
    logic din_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ss_rise_s;
    logic ss_fall_s;

    // Frame state
    state_t      state_q,  state_d;
    logic [31:0] rreg_q,   rreg_d;
    logic [31:0] treg_q,   treg_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic        order_q,  order_d;
    logic [3:0]  settle_q, settle_d;

    // Registered outputs
    logic [31:0] data_received_q, data_received_d;
    logic        done_q,          done_d;
    logic        busy_q,          busy_d;
    logic        frame_error_q,   frame_error_d;
    logic        dout_q,          dout_d;
    logic        dout_en_q,       dout_en_d;

    // Bring the asynchronous host pins into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            din_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   bus.ss};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0],  bus.din};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s =  sclk_s & ~sclk_hist_q;
    assign sclk_fall_s = ~sclk_s &  sclk_hist_q;
    assign ss_rise_s   =  ss_s   & ~ss_hist_q;
    assign ss_fall_s   = ~ss_s   &  ss_hist_q;

    // Frame state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= WAIT_SS;
            rreg_q          <= 32'hFFFF_FFFF;
            treg_q          <= 32'hFFFF_FFFF;
            bitcnt_q        <= 6'd0;
            order_q         <= 1'b1;
            settle_q        <= 4'd0;
            data_received_q <= 32'h0000_0000;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            frame_error_q   <= 1'b0;
            dout_q          <= 1'b1;
            dout_en_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rreg_q          <= rreg_d;
            treg_q          <= treg_d;
            bitcnt_q        <= bitcnt_d;
            order_q         <= order_d;
            settle_q        <= settle_d;
            data_received_q <= data_received_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            frame_error_q   <= frame_error_d;
            dout_q          <= dout_d;
            dout_en_q       <= dout_en_d;
        end
    end

    // Next-state, shift-register and output decisions
    always_comb begin
        state_d         = state_q;
        rreg_d          = rreg_q;
        treg_d          = treg_q;
        bitcnt_d        = bitcnt_q;
        order_d         = order_q;
        settle_d        = settle_q;
        data_received_d = data_received_q;
        done_d          = 1'b0;
        frame_error_d   = 1'b0;
        dout_d          = dout_q;

        case (state_q)
            WAIT_SS: begin
                // Do not trust ss until the synchronizer holds real pin data,
                // so an ss held low through reset cannot start a frame.
                dout_d = 1'b1;
                if (settle_q != SETTLE_CNT) begin
                    settle_d = settle_q + 4'd1;
                end else begin
                    if (ss_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_SS;
                    end
                end
            end

            IDLE: begin
                if (ss_fall_s) begin
                    treg_d   = bus.data_transmit;
                    order_d  = bus.mlb;
                    bitcnt_d = 6'd0;
                    dout_d   = bus.mlb ? bus.data_transmit[31] : bus.data_transmit[0];
                    state_d  = ACTIVE;
                end else begin
                    dout_d   = 1'b1;
                end
            end

            ACTIVE: begin
                // ss rise outranks any sclk edge seen in the same cycle
                if (ss_rise_s && (bitcnt_q != FRAME_CNT)) begin
                    if (bitcnt_q != 6'd0) begin
                        frame_error_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b0;
                    end
                    dout_d  = 1'b1;
                    state_d = IDLE;
                end else if (bitcnt_q == FRAME_CNT) begin
                    data_received_d = rreg_q;
                    done_d          = 1'b1;
                    dout_d          = 1'b1;
                    state_d         = COMPLETE;
                end else if (sclk_rise_s) begin
                    if (order_q) begin
                        rreg_d = {rreg_q[30:0], din_s};
                    end else begin
                        rreg_d = {din_s, rreg_q[31:1]};
                    end
                    bitcnt_d = bitcnt_q + 6'd1;
                end else if (sclk_fall_s) begin
                    // bitcnt is below FRAME_CNT here; the full case left above
                    if (order_q) begin
                        treg_d = {treg_q[30:0], 1'b1};
                        dout_d = treg_q[30];
                    end else begin
                        treg_d = {1'b1, treg_q[31:1]};
                        dout_d = treg_q[1];
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end

            COMPLETE: begin
                // Surplus sclk edges are ignored until the host deselects
                dout_d = 1'b1;
                if (ss_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = COMPLETE;
                end
            end

            default: begin
                dout_d  = 1'b1;
                state_d = WAIT_SS;
            end
        endcase

        busy_d    = (state_d == ACTIVE);
        dout_en_d = (state_d == ACTIVE) || (state_d == COMPLETE);
    end

    assign bus.data_received = data_received_q;
    assign bus.done          = done_q;
    assign bus.busy          = busy_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.dout          = dout_q;
    assign bus.dout_en       = dout_en_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the FPGA fabric: the far end of the team's 32-bit SPI master link, used when this board is clocked by an external SPI host instead of driving the bus itself. It oversamples `sclk`, `ss` and `din` on the system clock and shifts a 32-bit frame in and out, MSB- or LSB-first. Each completed frame is delivered on the parallel side with a one-cycle `done` strobe. The bus format matches the master: `sclk` idles low, data is sampled on `sclk` rising and changed on `sclk` falling, `ss` is active-low, and `dout` idles at 1.

## Interface
- `FRAME_BITS`, default 32: bits per frame; fixed at 32, range checked by the bench only.
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `ss` and `din`; must be ≥ 2.

- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_transmit`  in  32  word returned to the host; sampled on the `ss` falling edge.
- `mlb`  in  1  bit order: 0 = LSB first, 1 = MSB first; sampled on the `ss` falling edge.
- `data_received`  out  32  last complete word received from the host.
- `done`  out  1  one-cycle pulse when `data_received` updates.
- `busy`  out  1  high while a frame is in progress (ACTIVE state).
- `frame_error`  out  1  one-cycle pulse when `ss` rises mid-frame.
- `sclk`  in  1  SPI clock from the host; asynchronous.
- `ss`  in  1  slave select from the host; active-low, asynchronous.
- `din`  in  1  MOSI, host to slave.
- `dout`  out  1  MISO, slave to host.
- `dout_en`  out  1  MISO output enable for the pad tristate.

## Operation
- Synchronization:
  - `sclk`, `ss` and `din` each pass through `SYNC_STAGES` flops, plus one history flop for edge detection.
  - Synchronizer flops reset to `sclk`=0, `ss`=1, `din`=1.
  - Edges are detected from the synchronized value versus the history flop.
- Registers:
  - `rreg`[31:0] receive shift register.
  - `treg`[31:0] transmit shift register.
  - `bitcnt`[5:0] counts sampled bits, 0..32.
  - `order` holds the latched `mlb`.
- States:
  - WAIT_SS:
    - Entered on reset.
    - Stays until synchronized `ss`=1, then goes to IDLE.
    - Prevents a frame from starting on an `ss` held low through reset.
  - IDLE:
    - Outputs `dout`=1, `dout_en`=0.
    - On `ss` fall: `treg`←`data_transmit`, `order`←`mlb`, `bitcnt`←0.
    - Also on `ss` fall: `dout`←`data_transmit[31]` if `mlb`=1, else `data_transmit[0]`. Then go to ACTIVE.
  - ACTIVE:
    - Outputs `busy`=1, `dout_en`=1.
    - On `sclk` rise: shift in the synchronized `din`.
      - `order`=1: `rreg`←{`rreg`[30:0], din}.
      - `order`=0: `rreg`←{din, `rreg`[31:1]}.
      - Then `bitcnt`+1.
    - On `sclk` fall with `bitcnt`<32: shift `treg` and present the next bit.
      - `order`=1: shift left with 1 fill, `dout`←new `treg[31]`.
      - `order`=0: shift right with 1 fill, `dout`←new `treg[0]`.
    - When `bitcnt` reaches 32 (on the cycle after the 32nd rise): `data_received`←`rreg`, `done`=1 for one cycle, go to COMPLETE.
    - On `ss` rise with 0<`bitcnt`<32: `frame_error`=1 for one cycle, go to IDLE, `data_received` unchanged.
    - On `ss` rise with `bitcnt`=0: go to IDLE silently.
  - COMPLETE:
    - Outputs `dout`=1, `dout_en`=1.
    - Extra `sclk` edges are ignored; `bitcnt` does not increment.
    - On `ss` rise: go to IDLE with no error.
- Simultaneous events:
  - `ss` rise in the same cycle as an `sclk` edge: the `ss` rise wins and the `sclk` edge is discarded.
  - 32nd `sclk` rise together with `ss` rise: treated as an abort, so `frame_error`=1 and no `done`.
- Reset mid-frame:
  - Aborts immediately with no `done` and no `frame_error`.
  - All outputs take their reset values; the block goes to WAIT_SS.

## Timing
- Reset values:
  - `data_received`=0, `done`=0, `busy`=0, `frame_error`=0.
  - `dout`=1, `dout_en`=0.
  - `rreg`=FFFFFFFF, `treg`=FFFFFFFF, `bitcnt`=0.
- Pin-edge to internal action: `SYNC_STAGES`+1 clock cycles (3 by default).
  - Action register updates on the following edge.
- Pin-edge to `dout` change: ≤ 4 clock cycles.
- Host constraints:
  - Each `sclk` high and low phase ≥ 6 clock cycles.
  - `ss` fall to first `sclk` rise ≥ 6 cycles.
  - Last `sclk` fall to `ss` rise ≥ 4 cycles.
  - With the team master on the same clock, this requires clock_div ≥ 2.
- `done` latency: asserted 1 cycle after the 32nd rise is detected internally.
- `done` and `frame_error` are never high in the same cycle.
- `busy` falls in the same cycle `done` rises.
- `data_transmit` and `mlb` may change freely outside the `ss` fall capture cycle.

## Test plan
- **MSB-first loopback:**
  - Stimulus: `mlb`=1, `data_transmit`=A5A5_1234; host sends C0FF_EE01 at 8 clocks per phase.
  - Required: host receives A5A5_1234; `data_received`=C0FF_EE01; single `done` pulse; `frame_error` never high.
- **LSB-first:**
  - Stimulus: `mlb`=0, `data_transmit`=0000_0001; host sends 8000_0000.
  - Required: first MISO bit is 1, remaining 31 bits are 0; `data_received`=8000_0000.
- **Aborted frame:**
  - Stimulus: `ss` rises after 17 clocks, following a completed frame that left `data_received`=1111_1111.
  - Required: one `frame_error` pulse; `data_received` stays 1111_1111; the next full frame completes normally.
- **Overlong frame:**
  - Stimulus: 40 `sclk` pulses in one `ss` window.
  - Required: `done` exactly once, after pulse 32; `dout`=1 during pulses 33–40.
- **Reset mid-frame:**
  - Stimulus: `reset` after bit 10 while `ss` is held low.
  - Required: outputs go to reset values; no frame starts until `ss` goes high then low; the subsequent frame is correct.
- **Back-to-back frames:**
  - Stimulus: frames with 6 clocks of `ss` high between them, `data_transmit` changed between frames.
  - Required: each frame returns the value present at its own `ss` fall.
